mux_rr_stage: RTL and testbench

//   Parametrised N-channel, W-bit multiplexer with a registered output stage
//   and valid/ready flow control. Generalises the 1-bit 2:1 select mux to
//   N channels of W bits.
//   Two selection modes: direct select, or round-robin over valid channels.

---
 rtl/mux_rr_stage.sv | 128 ++++++++++++
 tb/tb_mux_rr_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_stage.sv
// N-channel, W-bit multiplexer with direct or round-robin channel selection,
// feeding one registered output slot under a valid/ready handshake.
module mux_rr_stage #(
   parameter int W    = 8,
   parameter int N    = 4,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_chan,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [W-1:0]    out_data_q,  out_data_d;
   logic [SELW-1:0] out_chan_q,  out_chan_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] rr_last_q,   rr_last_d;

   logic            grant_valid_s;
   logic [SELW-1:0] grant_s;
   logic [SELW-1:0] rr_idx_s;
   logic [W-1:0]    grant_data_s;
   logic            can_accept_s;
   logic            xfer_s;

   // Grant selection: direct index or first valid channel after rr_last.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_s       = {SELW{1'b0}};
      rr_idx_s      = rr_last_q;
      if (mode == 1'b0) begin
         // Loop compare rather than indexing, so an out-of-range sel never grants.
         for (int i = 0; i < N; i++) begin
            if ((sel == SELW'(i)) && in_valid[i]) begin
               grant_valid_s = 1'b1;
               grant_s       = SELW'(i);
            end else begin
               grant_valid_s = grant_valid_s;
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (rr_idx_s == SELW'(N - 1)) begin
               rr_idx_s = {SELW{1'b0}};
            end else begin
               rr_idx_s = rr_idx_s + SELW'(1);
            end
            if (!grant_valid_s && in_valid[rr_idx_s]) begin
               grant_valid_s = 1'b1;
               grant_s       = rr_idx_s;
            end else begin
               grant_valid_s = grant_valid_s;
            end
         end
      end
   end

   // Data word of the granted channel.
   always_comb begin
      grant_data_s = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (grant_s == SELW'(i)) begin
            grant_data_s = in_data[i*W +: W];
         end else begin
            grant_data_s = grant_data_s;
         end
      end
   end

   // Handshake towards producers; reset suppresses all acceptance.
   always_comb begin
      can_accept_s = !out_valid_q || out_ready;
      xfer_s       = can_accept_s && grant_valid_s && !reset;
      in_ready     = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (xfer_s && (grant_s == SELW'(i))) begin
            in_ready[i] = 1'b1;
         end else begin
            in_ready[i] = 1'b0;
         end
      end
   end

   // Output slot next state: load on transfer, empty on drain, else hold.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      rr_last_d   = rr_last_q;
      if (xfer_s) begin
         out_data_d  = grant_data_s;
         out_chan_d  = grant_s;
         out_valid_d = 1'b1;
         rr_last_d   = grant_s;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers; rr_last resets to N-1 so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= {W{1'b0}};
         out_chan_q  <= {SELW{1'b0}};
         out_valid_q <= 1'b0;
         rr_last_q   <= SELW'(N - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stage.sv
// Scoreboard bench for mux_rr_stage (W=8, N=4): directed vectors with
// hand-computed expectations, then a randomised run against a reference model.
module tb_mux_rr_stage;
   localparam int W = 8;
   localparam int N = 4;
   localparam int SELW = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            mode = 1'b0;
   logic [SELW-1:0] sel = 2'd0;
   logic [N*W-1:0]  in_data = 32'h0;
   logic [N-1:0]    in_valid = 4'h0;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic [SELW-1:0] out_chan;
   logic            out_valid;
   logic            out_ready = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   // expected words {chan, data} in load order
   logic [SELW+W-1:0] sb_q[$];
   bit m_known = 1'b0;
   bit m_valid = 1'b0;
   int m_rr = N - 1;

   mux_rr_stage #(.W(W), .N(N), .SELW(SELW)) dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference grant: scan channels in priority order derived from the mode.
   task automatic mdl_grant(input bit md, input logic [1:0] s, input logic [3:0] v,
                            input int rr, output bit gv, output int g);
      gv = 1'b0;
      g = 0;
      if (!md) begin
         gv = v[s];
         g = int'(s);
      end else begin
         for (int off = 1; off <= N; off++) begin
            if (!gv && v[(rr + off) % N]) begin
               gv = 1'b1;
               g = (rr + off) % N;
            end
         end
      end
   endtask

   // One cycle: drive inputs on the falling edge, check, then advance the model.
   task automatic step(input bit rst, input bit md, input logic [1:0] s,
                       input logic [3:0] v, input logic [31:0] d, input bit rdy,
                       input int e_ir, input int e_ov, input int e_ch, input int e_dt);
      bit gv;
      int g;
      logic [3:0] m_ir;
      @(negedge clk);
      reset = rst; mode = md; sel = s; in_valid = v; in_data = d; out_ready = rdy;
      #1;
      mdl_grant(md, s, v, m_rr, gv, g);
      m_ir = 4'h0;
      if (!rst && gv && (!m_valid || rdy)) m_ir[g] = 1'b1;
      if (m_known) begin
         chk("in_ready_model", {28'h0, in_ready}, {28'h0, m_ir});
         chk("out_valid_model", {31'h0, out_valid}, {31'h0, m_valid});
      end
      if (e_ir >= 0) chk("in_ready_hand", {28'h0, in_ready}, e_ir);
      if (e_ov >= 0) chk("out_valid_hand", {31'h0, out_valid}, e_ov);
      if (e_ch >= 0) chk("out_chan_hand", {30'h0, out_chan}, e_ch);
      if (e_dt >= 0) chk("out_data_hand", {24'h0, out_data}, e_dt);
      if (rst) begin
         sb_q.delete();
         m_valid = 1'b0;
         m_rr = N - 1;
         m_known = 1'b1;
      end else if (m_ir != 4'h0) begin
         sb_q.push_back({g[1:0], d[g*W +: W]});
         m_valid = 1'b1;
         m_rr = g;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   // Monitor: each word taken by the consumer must match the oldest expected word.
   initial begin
      logic [SELW+W-1:0] exp_w;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_word", {22'h0, out_chan, out_data}, 32'hFFFF_FFFF);
            end else begin
               exp_w = sb_q.pop_front();
               chk("sb_word", {22'h0, out_chan, out_data}, {22'h0, exp_w});
            end
         end
      end
   end

   initial begin
      // reset held two cycles with every channel requesting
      step(1, 1, 2'd0, 4'hF, 32'h13121110, 1, 0, -1, -1, -1);
      step(1, 1, 2'd0, 4'hF, 32'h13121110, 1, 0, 0, 0, 0);
      // direct select of ch2, then an unrequested ch3
      step(0, 0, 2'd2, 4'h4, 32'h00A50000, 1, 4'h4, 0, -1, -1);
      step(0, 0, 2'd3, 4'h4, 32'h00A50000, 1, 0, 1, 2, 8'hA5);
      step(0, 0, 2'd3, 4'h0, 32'h00A50000, 1, 0, 0, -1, -1);
      // round-robin from reset, all valid, then ch0/ch3 only
      step(1, 1, 2'd0, 4'h0, 32'h0, 1, 0, -1, -1, -1);
      step(0, 1, 2'd0, 4'hF, 32'h13121110, 1, 4'h1, 0, -1, -1);
      step(0, 1, 2'd0, 4'hF, 32'h13121110, 1, 4'h2, 1, 0, 8'h10);
      step(0, 1, 2'd0, 4'hF, 32'h13121110, 1, 4'h4, 1, 1, 8'h11);
      step(0, 1, 2'd0, 4'hF, 32'h13121110, 1, 4'h8, 1, 2, 8'h12);
      step(0, 1, 2'd0, 4'hF, 32'h13121110, 1, 4'h1, 1, 3, 8'h13);
      step(0, 1, 2'd0, 4'h9, 32'h13121110, 1, 4'h8, 1, 0, 8'h10);
      step(0, 1, 2'd0, 4'h9, 32'h13121110, 1, 4'h1, 1, 3, 8'h13);
      step(0, 1, 2'd0, 4'h9, 32'h13121110, 1, 4'h8, 1, 0, 8'h10);
      step(0, 1, 2'd0, 4'h0, 32'h13121110, 1, 0, 1, 3, 8'h13);
      step(0, 1, 2'd0, 4'h0, 32'h0, 1, 0, 0, -1, -1);
      // backpressure with 5A held while d1 changes, then same-cycle refill
      step(0, 0, 2'd1, 4'h2, 32'h00005A00, 1, 4'h2, 0, -1, -1);
      step(0, 0, 2'd1, 4'h2, 32'h00006600, 0, 0, 1, 1, 8'h5A);
      step(0, 0, 2'd1, 4'h2, 32'h00007700, 0, 0, 1, 1, 8'h5A);
      step(0, 0, 2'd1, 4'h2, 32'h00008800, 0, 0, 1, 1, 8'h5A);
      step(0, 0, 2'd1, 4'h2, 32'h00008800, 1, 4'h2, 1, 1, 8'h5A);
      step(0, 0, 2'd1, 4'h0, 32'h0, 1, 0, 1, 1, 8'h88);
      step(0, 0, 2'd1, 4'h0, 32'h0, 1, 0, 0, -1, -1);
      // reset during a stall discards the word; round-robin restarts at ch0
      step(0, 1, 2'd0, 4'h4, 32'h00CC0000, 0, 4'h4, 0, -1, -1);
      step(0, 1, 2'd0, 4'h0, 32'h0, 0, 0, 1, 2, 8'hCC);
      step(1, 1, 2'd0, 4'h0, 32'h0, 0, 0, 1, -1, -1);
      step(0, 1, 2'd0, 4'hF, 32'h13121110, 0, 4'h1, 0, 0, 0);
      step(0, 1, 2'd0, 4'h0, 32'h0, 1, 0, 1, 0, 8'h10);
      step(0, 1, 2'd0, 4'h0, 32'h0, 1, 0, 0, -1, -1);
      // randomised traffic checked only against the model and scoreboard
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 3) != 0), -1, -1, -1, -1);
      end
      step(0, 0, 2'd0, 4'h0, 32'h0, 1, -1, -1, -1, -1);
      step(0, 0, 2'd0, 4'h0, 32'h0, 1, -1, -1, -1, -1);
      step(0, 0, 2'd0, 4'h0, 32'h0, 1, 0, 0, -1, -1);
      @(negedge clk);
      #5;
      chk("sb_empty_at_end", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
